pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_sat_counter.sv | 24 ++
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  // Defaults match the ID/EX field set.
  localparam int WB_W_DEF     = 4;
  localparam int MEM_W_DEF    = 5;
  localparam int EX_W_DEF     = 9;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_DATA_DEF = 5;
  localparam int REG_W_DEF    = 5;
  localparam int NUM_REG_DEF  = 2;
  localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush and a
// downstream-stall counter.
//
// state | meaning
// EMPTY | nothing held; outputs show a bubble
// FULL  | MAIN holds the bundle presented downstream
// SKID  | MAIN and SKID both hold bundles; upstream is back-pressured
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WB_W     = WB_W_DEF,
  parameter int MEM_W    = MEM_W_DEF,
  parameter int EX_W     = EX_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_DATA = NUM_DATA_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int NUM_REG  = NUM_REG_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WB_W-1:0]             in_wb_ctrl,
  input  logic [MEM_W-1:0]            in_mem_ctrl,
  input  logic [EX_W-1:0]             in_ex_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]  in_data,
  input  logic [NUM_REG*REG_W-1:0]    in_reg,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WB_W-1:0]             out_wb_ctrl,
  output logic [MEM_W-1:0]            out_mem_ctrl,
  output logic [EX_W-1:0]             out_ex_ctrl,
  output logic [NUM_DATA*DATA_W-1:0]  out_data,
  output logic [NUM_REG*REG_W-1:0]    out_reg,
  input  logic                        stat_clr,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int D_W   = NUM_DATA * DATA_W;
  localparam int R_W   = NUM_REG * REG_W;
  localparam int EX_LO = R_W + D_W;
  localparam int MEM_LO = EX_LO + EX_W;
  localparam int WB_LO = MEM_LO + MEM_W;
  localparam int BW    = WB_LO + WB_W;

  pipe_state_e   state;
  logic [BW-1:0] main_q;
  logic [BW-1:0] skid_q;
  logic [BW-1:0] in_bundle;
  logic          accept;
  logic          drain;

  assign in_bundle = {in_wb_ctrl, in_mem_ctrl, in_ex_ctrl, in_data, in_reg};

  // Handshake outputs depend on state only, so out_ready never reaches in_ready.
  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_bundle;
            state  <= FULL;
          end
        end
        FULL: begin
          if (accept && !drain) begin
            skid_q <= in_bundle;
            state  <= SKID;
          end else if (accept && drain) begin
            main_q <= in_bundle;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (drain) begin
            main_q <= skid_q;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Control fields read as a bubble when nothing is valid; payload keeps last MAIN.
  assign out_wb_ctrl  = out_valid ? main_q[WB_LO +: WB_W]   : '0;
  assign out_mem_ctrl = out_valid ? main_q[MEM_LO +: MEM_W] : '0;
  assign out_ex_ctrl  = out_valid ? main_q[EX_LO +: EX_W]   : '0;
  assign out_data     = main_q[R_W +: D_W];
  assign out_reg      = main_q[R_W-1:0];

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (out_valid && !out_ready),
    .clr   (stat_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model with a negedge
// monitor, directed scenarios, then randomized traffic.
module tb_pipe_stage_reg;

  localparam int BW = 188;
  typedef logic [BW-1:0] bnd_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  logic stat_clr = 1'b0;
  bnd_t in_b = '0;

  logic [3:0]   in_wb;
  logic [4:0]   in_mem;
  logic [8:0]   in_ex;
  logic [159:0] in_data;
  logic [9:0]   in_reg;
  assign {in_wb, in_mem, in_ex, in_data, in_reg} = in_b;

  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [3:0]   wb_a, wb_b;
  logic [4:0]   mem_a, mem_b;
  logic [8:0]   ex_a, ex_b;
  logic [159:0] data_a, data_b;
  logic [9:0]   reg_a, reg_b;
  logic [15:0]  stall_a;
  logic [3:0]   stall_b;
  bnd_t         out_b_a, out_b_b;
  assign out_b_a = {wb_a, mem_a, ex_a, data_a, reg_a};
  assign out_b_b = {wb_b, mem_b, ex_b, data_b, reg_b};

  pipe_stage_reg dut_a (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_wb_ctrl(in_wb), .in_mem_ctrl(in_mem), .in_ex_ctrl(in_ex),
    .in_data(in_data), .in_reg(in_reg), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_wb_ctrl(wb_a), .out_mem_ctrl(mem_a), .out_ex_ctrl(ex_a),
    .out_data(data_a), .out_reg(reg_a), .stat_clr(stat_clr), .stall_cnt(stall_a)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_wb_ctrl(in_wb), .in_mem_ctrl(in_mem), .in_ex_ctrl(in_ex),
    .in_data(in_data), .in_reg(in_reg), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_wb_ctrl(wb_b), .out_mem_ctrl(mem_b), .out_ex_ctrl(ex_b),
    .out_data(data_b), .out_reg(reg_b), .stat_clr(stat_clr), .stall_cnt(stall_b)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO of accepted bundles, capacity two.
  bnd_t held[$];
  bnd_t last_main = '0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  bit   model_ok = 1'b0;

  task automatic check_port(input string p, input logic v, input logic r, input bnd_t o,
                            input logic [15:0] sc, input int ecnt);
    chk({p, "_in_ready"}, r, held.size() < 2);
    chk({p, "_out_valid"}, v, held.size() > 0);
    if (held.size() > 0) begin
      chk({p, "_bundle"}, o, held[0]);
    end else begin
      chk({p, "_bubble_ctrl"}, o[187:170], 18'h0);
      chk({p, "_hold_payload"}, o[169:0], last_main[169:0]);
    end
    chk({p, "_stall_cnt"}, sc, ecnt);
  endtask

  always @(negedge Clk) begin
    bit acc, drn;
    if (model_ok) begin
      check_port("a", out_valid_a, in_ready_a, out_b_a, stall_a, cnt_a);
      check_port("b", out_valid_b, in_ready_b, out_b_b, {12'h0, stall_b}, cnt_b);
    end
    acc = in_valid && (held.size() < 2);
    drn = (held.size() > 0) && out_ready;
    if (Reset) begin
      held.delete();
      last_main = '0;
      cnt_a = 0;
      cnt_b = 0;
      model_ok = 1'b1;
    end else begin
      if (stat_clr) begin
        cnt_a = 0;
        cnt_b = 0;
      end else if (held.size() > 0 && !out_ready) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_b < 15) cnt_b++;
      end
      if (flush) begin
        held.delete();
      end else begin
        if (drn) void'(held.pop_front());
        if (acc) held.push_back(in_b);
      end
      if (held.size() > 0) last_main = held[0];
    end
  end

  task automatic step(input logic v, input bnd_t b, input logic rdy, input logic fl,
                      input logic clr, input logic rst);
    in_valid = v; in_b = b; out_ready = rdy; flush = fl; stat_clr = clr; Reset = rst;
    @(posedge Clk);
    #1;
  endtask

  function automatic bnd_t mk(input int n);
    logic [159:0] d;
    for (int k = 0; k < 5; k++) d[k*32 +: 32] = 32'(n * 16 + k);
    return {4'(n), 5'(n), 9'(n), d, 5'(n), 5'(~n)};
  endfunction

  function automatic bnd_t rnd();
    return bnd_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    bnd_t b37;
    step(0, '0, 1, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_outputs", out_b_a, 0);
    chk("rst_stall", stall_a, 0);
    step(0, '0, 1, 0, 0, 0);

    // single bundle, one-cycle latency
    b37 = {4'hA, 5'h0, 9'h0, 128'h0, 32'h0000_0004, 10'h0};
    step(1, b37, 1, 0, 0, 0);
    chk("single_valid", out_valid_a, 1);
    chk("single_bundle", out_b_a, b37);
    step(0, '0, 1, 0, 0, 0);
    chk("single_gone", out_valid_a, 0);
    chk("single_wb_bubble", wb_a, 0);
    chk("single_word0_hold", data_a[31:0], 32'h4);

    // back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      chk("stream_in_ready", in_ready_a, 1);
      step(1, mk(i), 1, 0, 0, 0);
      chk("stream_bundle", out_b_a, mk(i));
    end
    step(0, '0, 1, 0, 0, 0);

    // downstream stall fills skid
    step(0, '0, 1, 0, 1, 0);
    step(1, mk(1), 0, 0, 0, 0);
    step(1, mk(2), 0, 0, 0, 0);
    chk("skid_in_ready", in_ready_a, 0);
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    chk("skid_stall_cnt", stall_a, 3);
    chk("skid_head", out_b_a, mk(1));
    step(0, '0, 1, 0, 0, 0);
    chk("skid_second", out_b_a, mk(2));
    chk("skid_stall_hold", stall_a, 3);
    step(0, '0, 1, 0, 0, 0);
    chk("skid_drained", out_valid_a, 0);

    // flush in SKID with a new bundle presented
    step(1, mk(1), 0, 0, 0, 0);
    step(1, mk(2), 0, 0, 0, 0);
    step(1, mk(3), 0, 1, 0, 0);
    chk("flush_valid", out_valid_a, 0);
    chk("flush_ctrl", {wb_a, mem_a, ex_a}, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, 0, 0, 0);
      chk("flush_no_emerge", out_valid_a, 0);
    end

    // stall counter saturation on the 4-bit instance
    step(0, '0, 1, 0, 1, 0);
    step(1, mk(5), 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0, 0);
    chk("sat_cnt4", stall_b, 4'd15);
    chk("sat_cnt16", stall_a, 16'd20);
    step(0, '0, 0, 0, 1, 0);
    chk("clr_cnt4", stall_b, 0);
    chk("clr_cnt16", stall_a, 0);

    // reset while FULL and stalled
    step(1, mk(7), 0, 0, 0, 1);
    chk("midrst_valid", out_valid_a, 0);
    chk("midrst_ready", in_ready_a, 1);
    chk("midrst_outputs", out_b_a, 0);
    chk("midrst_stall", stall_a, 0);
    step(0, '0, 1, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 299) == 0);
    end

    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0, 0);
    chk("final_empty", out_valid_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
